// File: rtl/axi4_heater_multi.sv
// Multi-channel heater PWM controller behind an AXI4-Lite slave.
// Optional HEATER_TIMEOUT_EN adds the TIMEOUT/ELAPSED run-time watchdog.
module axi4_heater_multi #(
    parameter int NUM_CH             = 4,
    parameter int PWM_W              = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_CH-1:0]             heat_en,
    output logic                          timeout_irq
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q, rdata_d;
    logic wr_en, rd_en;
    logic [AW-3:0] aw_word, ar_word;
    logic [31:0] wmask;
    logic en_q, en_d, to_q;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [PWM_W-1:0] period_q, period_d, per_eff, cnt_q, cnt_d;
    logic [NUM_CH-1:0][PWM_W-1:0] duty_vec;
    logic [31:0] timeout_val, elapsed_val;
    logic restart, timeout_hit;
    logic sel_ctrl, sel_mask, sel_period;
    logic unused_ok;

    assign aw_word = S_AXI_AWADDR[AW-1:2];
    assign ar_word = S_AXI_ARADDR[AW-1:2];
    // AWREADY is only raised once both channels are valid, so both are still valid here
    assign wr_en = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en = arready_q & S_AXI_ARVALID;
    assign wmask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign sel_ctrl   = wr_en & (32'(aw_word) == 32'd0);
    assign sel_mask   = wr_en & (32'(aw_word) == 32'd1);
    assign sel_period = wr_en & (32'(aw_word) == 32'd2);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
            if (wr_en)             bvalid_q <= 1'b1;
            else if (S_AXI_BREADY) bvalid_q <= 1'b0;
            arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        en_d     = en_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (timeout_hit) en_d = 1'b0;
        if (sel_ctrl && S_AXI_WSTRB[0]) en_d = S_AXI_WDATA[0];
        // an EN=1 write coinciding with a timeout restarts the run instead of stopping it
        restart = sel_ctrl & S_AXI_WSTRB[0] & S_AXI_WDATA[0] & (~en_q | timeout_hit);
        if (sel_mask)
            mask_d = (mask_q & ~wmask[NUM_CH-1:0]) | (S_AXI_WDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
        if (sel_period)
            period_d = (period_q & ~wmask[PWM_W-1:0]) | (S_AXI_WDATA[PWM_W-1:0] & wmask[PWM_W-1:0]);
        per_eff = (period_q == '0) ? PWM_W'(1) : period_q;
        if (restart)                          cnt_d = '0;
        else if (en_q)                        cnt_d = (cnt_q >= per_eff - PWM_W'(1)) ? '0 : cnt_q + PWM_W'(1);
        else if (cnt_q >= per_eff)            cnt_d = '0;
        else                                  cnt_d = cnt_q;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            en_q     <= 1'b0;
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            en_q     <= en_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PWM_W-1:0] duty_q, duty_d;
            logic heat_q;
            always_comb begin
                duty_d = duty_q;
                if (wr_en && (32'(aw_word) == 32'(16 + gi)))
                    duty_d = (duty_q & ~wmask[PWM_W-1:0]) | (S_AXI_WDATA[PWM_W-1:0] & wmask[PWM_W-1:0]);
            end
            always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
                if (S_AXI_ARESET) begin
                    duty_q <= '0;
                    heat_q <= 1'b0;
                end else begin
                    duty_q <= duty_d;
                    heat_q <= en_q & mask_q[gi] & (cnt_q < duty_q);
                end
            end
            assign duty_vec[gi] = duty_q;
            assign heat_en[gi]  = heat_q;
        end
    endgenerate

`ifdef HEATER_TIMEOUT_EN
    logic [31:0] timeout_q, elapsed_q;
    logic sel_timeout, sel_status;
    assign sel_timeout = wr_en & (32'(aw_word) == 32'd3);
    assign sel_status  = wr_en & (32'(aw_word) == 32'd4);
    assign timeout_hit = en_q & (timeout_q != 32'd0) & (elapsed_q == timeout_q - 32'd1);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            timeout_q <= '0;
            elapsed_q <= '0;
            to_q      <= 1'b0;
        end else begin
            if (sel_timeout) timeout_q <= (timeout_q & ~wmask) | (S_AXI_WDATA & wmask);
            if (restart)                            elapsed_q <= '0;
            else if (en_q && (elapsed_q != '1))     elapsed_q <= elapsed_q + 32'd1;
            if (timeout_hit)                                             to_q <= 1'b1;
            else if (sel_status && S_AXI_WSTRB[0] && S_AXI_WDATA[1])     to_q <= 1'b0;
        end
    end
    assign timeout_val = timeout_q;
    assign elapsed_val = elapsed_q;
`else
    assign timeout_hit = 1'b0;
    assign to_q        = 1'b0;
    assign timeout_val = '0;
    assign elapsed_val = '0;
`endif

    always_comb begin
        rdata_d = '0;
        case (32'(ar_word))
            32'd0:   rdata_d = {31'd0, en_q};
            32'd1:   rdata_d = 32'(mask_q);
            32'd2:   rdata_d = 32'(period_q);
            32'd3:   rdata_d = timeout_val;
            32'd4:   rdata_d = {30'd0, to_q, en_q};
            32'd5:   rdata_d = elapsed_val;
            default: rdata_d = '0;
        endcase
        for (int k = 0; k < NUM_CH; k++)
            if (32'(ar_word) == 32'(16 + k)) rdata_d = 32'(duty_vec[k]);
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign timeout_irq   = to_q;
    assign unused_ok = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wmask, S_AXI_WDATA};
endmodule

// File: tb/tb_axi4_heater_multi.sv
// Directed bench for axi4_heater_multi: register map, strobes, PWM patterns,
// AXI handshake corner cases, timeout (when HEATER_TIMEOUT_EN is defined) and async reset.
module tb_axi4_heater_multi;
`ifdef HEATER_TIMEOUT_EN
    localparam logic [31:0] EXP_TO = 32'd4;
`else
    localparam logic [31:0] EXP_TO = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  heat_en;
    logic        timeout_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi4_heater_multi #(.NUM_CH(4), .PWM_W(16), .C_S_AXI_ADDR_WIDTH(8)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .heat_en(heat_en), .timeout_irq(timeout_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin step(1); n++; end
        check("wr_awready", 32'(awready), 32'd1);
        check("wr_wready", 32'(wready), 32'd1);
        step(1);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin step(1); n++; end
        check("wr_bvalid", 32'(bvalid), 32'd1);
        check("wr_bresp", 32'(bresp), 32'd0);
        $display("WR addr=0x%02h data=0x%08h strb=0x%h bresp=%0d", addr, data, strb, bresp);
        step(1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin step(1); n++; end
        check("rd_arready", 32'(arready), 32'd1);
        step(1);
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin step(1); n++; end
        check("rd_rvalid", 32'(rvalid), 32'd1);
        check("rd_rresp", 32'(rresp), 32'd0);
        data = rdata;
        $display("RD addr=0x%02h data=0x%08h rresp=%0d", addr, data, rresp);
        step(1);
        rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int errs, hi, n;
        logic [3:0] acc_or, acc_and;
        logic acc, e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_heat_en", 32'(heat_en), 32'd0);
        check("rst_irq", 32'(timeout_irq), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;

        // register readback
        axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h04, 32'h2, 4'hF);
        axi_write(8'h08, 32'h3, 4'hF);
        axi_write(8'h0C, 32'h4, 4'hF);
        rd_check("rb_ctrl", 8'h00, 32'h1);
        rd_check("rb_mask", 8'h04, 32'h2);
        rd_check("rb_period", 8'h08, 32'h3);
        rd_check("rb_timeout", 8'h0C, EXP_TO);
        axi_write(8'h04, 32'hFFFF_FFFF, 4'hF);
        rd_check("rb_mask_trunc", 8'h04, 32'hF);
        axi_write(8'h0C, 32'h0, 4'hF);

        // byte strobes and unmapped space
        axi_write(8'h08, 32'h0000_ABCD, 4'hF);
        axi_write(8'h08, 32'h0000_1234, 4'b0010);
        rd_check("strb_period", 8'h08, 32'h0000_12CD);
        axi_write(8'h00, 32'h0, 4'b0000);
        rd_check("strb_ctrl_none", 8'h00, 32'h1);
        rd_check("status_run", 8'h10, 32'h1);
        axi_write(8'h50, 32'h77, 4'hF);
        rd_check("duty4_unmapped", 8'h50, 32'h0);
        rd_check("unmapped_18", 8'h18, 32'h0);
        rd_check("unmapped_3c", 8'h3C, 32'h0);
        axi_write(8'h00, 32'h0, 4'hF);

        // PERIOD=10, DUTY0=3, mask=1: 3 of 10 high, other channels masked
        axi_write(8'h08, 32'd10, 4'hF);
        axi_write(8'h40, 32'd3, 4'hF);
        axi_write(8'h4C, 32'd5, 4'hF);
        axi_write(8'h04, 32'h1, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        n = 0;
        while (heat_en[0] !== 1'b0 && n < 20) begin step(1); n++; end
        n = 0;
        while (heat_en[0] !== 1'b1 && n < 20) begin step(1); n++; end
        check("pwm_sync", 32'(heat_en[0]), 32'd1);
        errs = 0; hi = 0; acc_or = '0;
        for (int i = 0; i < 20; i++) begin
            e = ((i % 10) < 3);
            if (heat_en[0] !== e) errs++;
            if (heat_en[0] === 1'b1) hi++;
            acc_or = acc_or | heat_en;
            step(1);
        end
        check("pwm_ch0_pattern_errs", 32'(errs), 32'd0);
        check("pwm_ch0_high_count", 32'(hi), 32'd6);
        check("pwm_masked_ch", 32'(acc_or[3:1]), 32'd0);

        // DUTY=0 always low, DUTY>=PERIOD always high
        axi_write(8'h44, 32'd0, 4'hF);
        axi_write(8'h48, 32'd20, 4'hF);
        axi_write(8'h04, 32'h6, 4'hF);
        step(3);
        acc_or = '0; acc_and = 4'hF;
        for (int i = 0; i < 25; i++) begin
            acc_or = acc_or | heat_en;
            acc_and = acc_and & heat_en;
            step(1);
        end
        check("duty0_always_low", 32'(acc_or[1]), 32'd0);
        check("duty_ge_period_high", 32'(acc_and[2]), 32'd1);
        check("mask_off_ch0_ch3", 32'({acc_or[3], acc_or[0]}), 32'd0);

        // PERIOD=0 behaves as 1: DUTY=1 always on
        axi_write(8'h08, 32'd0, 4'hF);
        axi_write(8'h48, 32'd1, 4'hF);
        step(3);
        acc_and = 4'hF; acc_or = '0;
        for (int i = 0; i < 12; i++) begin
            acc_and = acc_and & heat_en;
            acc_or = acc_or | heat_en;
            step(1);
        end
        check("period0_duty1_high", 32'(acc_and[2]), 32'd1);
        check("period0_duty0_low", 32'(acc_or[1]), 32'd0);
        axi_write(8'h00, 32'h0, 4'hF);
        check("heat_off_after_disable", 32'(heat_en), 32'd0);

        // AWVALID ahead of WVALID, BREADY held low
        awaddr = 8'h08; wdata = 32'd7; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        acc = 1'b0;
        repeat (3) begin
            step(1);
            acc = acc | awready | wready;
        end
        check("aw_no_ready_without_w", 32'(acc), 32'd0);
        wvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 10) begin step(1); n++; end
        check("aw_ready_after_w", 32'(awready), 32'd1);
        check("aw_ready_latency", 32'(n), 32'd1);
        step(1);
        wdata = 32'd9;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) errs++;
            step(1);
        end
        check("bvalid_held_no_second_wr", 32'(errs), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        step(1);
        check("bvalid_cleared", 32'(bvalid), 32'd0);
        bready = 1'b0;
        $display("WR addr=0x08 data=0x00000007 strb=0xf (held-B sequence)");
        rd_check("single_write_only", 8'h08, 32'd7);

`ifdef HEATER_TIMEOUT_EN
        axi_write(8'h0C, 32'd100, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        n = 0;
        while (timeout_irq !== 1'b1 && n < 300) begin step(1); n++; end
        check("to_irq_set", 32'(timeout_irq), 32'd1);
        rd_check("to_ctrl_cleared", 8'h00, 32'h0);
        rd_check("to_elapsed", 8'h14, 32'd100);
        rd_check("to_status", 8'h10, 32'h2);
        axi_write(8'h10, 32'h2, 4'hF);
        check("to_irq_cleared", 32'(timeout_irq), 32'd0);
        rd_check("to_status_cleared", 8'h10, 32'h0);
        axi_write(8'h0C, 32'd0, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        step(120);
        check("to_zero_no_irq", 32'(timeout_irq), 32'd0);
        rd_check("to_zero_status", 8'h10, 32'h1);
        axi_read(8'h14, d);
        check("to_zero_elapsed_runs", 32'(d >= 32'd120), 32'd1);
        axi_write(8'h00, 32'h0, 4'hF);
`else
        axi_write(8'h0C, 32'h55, 4'hF);
        rd_check("timeout_reads_zero", 8'h0C, 32'h0);
        axi_write(8'h00, 32'h1, 4'hF);
        step(10);
        rd_check("elapsed_reads_zero", 8'h14, 32'h0);
        check("irq_tied_low", 32'(timeout_irq), 32'd0);
        axi_write(8'h10, 32'h2, 4'hF);
        rd_check("status_no_to", 8'h10, 32'h1);
        axi_write(8'h00, 32'h0, 4'hF);
`endif

        // asynchronous reset in the middle of a read with heaters on
        axi_write(8'h04, 32'h1, 4'hF);
        axi_write(8'h40, 32'd10, 4'hF);
        axi_write(8'h08, 32'd10, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        step(3);
        check("heat_before_rst", 32'(heat_en), 32'h1);
        araddr = 8'h00; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (arready !== 1'b1 && n < 10) begin step(1); n++; end
        check("rst_rd_arready", 32'(arready), 32'd1);
        step(1);
        arvalid = 1'b0;
        check("rst_rd_rvalid0", 32'(rvalid), 32'd1);
        step(1);
        check("rst_rd_rvalid_held", 32'(rvalid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_rvalid", 32'(rvalid), 32'd0);
        check("rst_async_heat_en", 32'(heat_en), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_check("ctrl_after_rst", 8'h00, 32'h0);
        rd_check("period_after_rst", 8'h08, 32'h0);
        check("heat_after_rst", 32'(heat_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
